// File: rtl/cp0_exception_unit.sv
// CP0 for the pipelined MIPS core: SR, Cause, EPC, PRId, interrupt synchronisation/masking,
// trap/eret sequencing and mtc0/mfc0 access, placed beside the M stage.
module cp0_exception_unit #(
  parameter int unsigned IRQ_WIDTH    = 6,
  parameter int unsigned IRQ_BASE     = 10,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_WIDTH-1:0] hw_int,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_epc,
  input  logic                 exc_bd,
  input  logic                 eret,
  input  logic                 mtc0_we,
  input  logic [4:0]           cp0_addr,
  input  logic [31:0]          cp0_wdata,
  output logic [31:0]          cp0_rdata,
  output logic                 take_trap,
  output logic [31:0]          handler_pc,
  output logic [31:0]          epc_out
);

  // Software may only touch the implemented IM bits plus EXL and IE.
  localparam logic [31:0] SrWmask = (((32'd1 << IRQ_WIDTH) - 32'd1) << IRQ_BASE) | 32'd3;

  logic [31:0]          sr_q, sr_d;
  logic [31:0]          cause_q, cause_d;
  logic [31:0]          epc_q, epc_d;
  logic [IRQ_WIDTH-1:0] ip_sync;
  logic                 int_pending;
  logic [4:0]           trap_code;
  logic                 unused_epc_lsb;

  assign unused_epc_lsb = ^exc_epc[1:0];

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign ip_sync = hw_int;
    end else begin : g_sync
      logic [IRQ_WIDTH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= hw_int;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign ip_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Pending is judged on the synced lines, not the registered Cause.IP copy.
  assign int_pending = (|(ip_sync & sr_q[IRQ_BASE +: IRQ_WIDTH])) & sr_q[0] & ~sr_q[1];
  assign take_trap   = int_pending | exc_valid;
  assign trap_code   = int_pending ? 5'd0 : exc_code;
  assign handler_pc  = HANDLER_ADDR;
  assign epc_out     = epc_q;

  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cause_d[IRQ_BASE +: IRQ_WIDTH] = ip_sync;
    if (take_trap) begin
      sr_d[1]      = 1'b1;
      cause_d[6:2] = trap_code;
      // A nested trap keeps the original return point and its BD flag.
      if (!sr_q[1]) begin
        cause_d[31] = exc_bd;
        epc_d       = {exc_epc[31:2], 2'b00};
      end
    end else if (eret) begin
      sr_d[1] = 1'b0;
    end else if (mtc0_we) begin
      case (cp0_addr)
        5'd12:   sr_d  = cp0_wdata & SrWmask;
        5'd14:   epc_d = {cp0_wdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      5'd12:   cp0_rdata = sr_q;
      5'd13:   cp0_rdata = cause_q;
      5'd14:   cp0_rdata = epc_q;
      5'd15:   cp0_rdata = PRID_VALUE;
      default: cp0_rdata = '0;
    endcase
  end

endmodule
